// File: rtl/pf_fetch.sv
// -----------------------------------------------------------------------------
// pf_fetch -- video-side reader for the 4-bank playfield RAM.
//
// Once per scanline, fetches H_PIXELS/32 32-bit words (four adjacent tile
// codes per word, byte n = column 4w+n) from RAM port B. It then streams one
// tile code per pixel-clock enable. The word after the one being displayed is
// prefetched into a second buffer, so every word swap happens with no gap.
//
// Optional feature macro: PF_FETCH_FLIP_EN
//   When defined, the module adds an input `flip` that is sampled at
//   line_start. With flip=1 the word order is 7..0, the byte order within a
//   word is 3..0, the tile row is ~vpos[7:3] and tile_line is ~vpos[2:0].
//
// Parameters
//   H_PIXELS  active pixels per line, a multiple of 32
//   RAM_LAT   clocks from an addr_b/ce_b change to valid dout_b (1..8)
//
// Ports
//   clk         in   system clock
//   reset       in   synchronous, active-high
//   pix_ce      in   pixel clock enable (one-clk pulses)
//   line_start  in   one-clk pulse, starts the fetch for scanline vpos
//   vpos[7:0]   in   scanline: [7:3] tile row, [2:0] row within tile
//   flip        in   (PF_FETCH_FLIP_EN only) mirrored fetch order
//   addr_b[7:0] out  RAM word address {tile row, word index}
//   ce_b[3:0]   out  RAM bank enables, active-low (4'h0 reading, 4'hF idle)
//   dout_b[31:0]in   RAM read data {bank3,bank2,bank1,bank0}
//   tile_code   out  tile code of the current pixel
//   tile_line   out  row within tile, latched at line_start
//   tile_px     out  pixel column within tile
//   tile_valid  out  high while tile_code/tile_line/tile_px are valid
// -----------------------------------------------------------------------------
module pf_fetch #(
    parameter int H_PIXELS = 256,
    parameter int RAM_LAT  = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pix_ce,
    input  logic        line_start,
    input  logic [7:0]  vpos,
`ifdef PF_FETCH_FLIP_EN
    input  logic        flip,
`endif
    output logic [7:0]  addr_b,
    output logic [3:0]  ce_b,
    input  logic [31:0] dout_b,
    output logic [7:0]  tile_code,
    output logic [2:0]  tile_line,
    output logic [2:0]  tile_px,
    output logic        tile_valid
);

    localparam int NWORDS = H_PIXELS / 32;
    localparam int PX_W   = $clog2(H_PIXELS);
    localparam int WI_W   = $clog2(NWORDS) + 1;
    localparam int CNT_W  = 3;

    typedef enum logic [1:0] {S_IDLE, S_F0, S_F1, S_RUN} state_t;

    state_t             r_state, w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [WI_W-1:0]    r_widx;
    logic [PX_W-1:0]    r_px;
    logic [4:0]         r_row;
    logic               r_flip;
    logic               r_fetch;
    logic [31:0]        r_active;
    logic [31:0]        r_next;
    logic [7:0]         r_addr_b;
    logic [3:0]         r_ce_b;
    logic [7:0]         r_tile_code;
    logic [2:0]         r_tile_line;
    logic [2:0]         r_tile_px;
    logic               r_tile_valid;

    logic               w_flip_in;
    logic               w_lat_done;
    logic               w_px_last;
    logic               w_boundary;
    logic               w_more;
    logic [PX_W-1:0]    w_px_inc;
    logic [WI_W-1:0]    w_widx_inc;
    logic [4:0]         w_row_new;
    logic [31:0]        w_src;

`ifdef PF_FETCH_FLIP_EN
    assign w_flip_in = flip;
`else
    assign w_flip_in = 1'b0;
`endif

    // Physical word within the row: only the low 3 bits reach addr_b.
    function automatic logic [2:0] f_word_addr(input logic [WI_W-1:0] w, input logic fl);
        return fl ? ~w[2:0] : w[2:0];
    endfunction

    function automatic logic [7:0] f_byte(input logic [31:0] word, input logic [1:0] sel,
                                          input logic fl);
        logic [1:0] b;
        b = fl ? ~sel : sel;
        return word[8*b +: 8];
    endfunction

    assign w_lat_done = (r_cnt == '0);
    assign w_px_last  = (r_px == PX_W'(H_PIXELS - 1));
    assign w_boundary = (r_px[4:0] == 5'd31);
    assign w_more     = (r_widx < WI_W'(NWORDS - 1));
    assign w_px_inc   = r_px + 1'b1;
    assign w_widx_inc = r_widx + 1'b1;
    assign w_row_new  = w_flip_in ? ~vpos[7:3] : vpos[7:3];
    // On a word boundary the prefetched word becomes current in the same clock.
    assign w_src      = w_boundary ? r_next : r_active;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (line_start) begin
            w_state_nxt = S_F0;
        end else begin
            unique case (r_state)
                S_IDLE: w_state_nxt = S_IDLE;
                S_F0:   if (w_lat_done) w_state_nxt = S_F1;
                S_F1:   if (w_lat_done) w_state_nxt = S_RUN;
                S_RUN:  if (pix_ce && w_px_last) w_state_nxt = S_IDLE;
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt        <= '0;
            r_widx       <= '0;
            r_px         <= '0;
            r_row        <= '0;
            r_flip       <= 1'b0;
            r_fetch      <= 1'b0;
            r_active     <= '0;
            r_next       <= '0;
            r_addr_b     <= '0;
            r_ce_b       <= 4'hF;
            r_tile_code  <= '0;
            r_tile_line  <= '0;
            r_tile_px    <= '0;
            r_tile_valid <= 1'b0;
        end else if (line_start) begin
            // A new line aborts whatever is in progress, including a pending fetch.
            r_flip       <= w_flip_in;
            r_row        <= w_row_new;
            r_tile_line  <= w_flip_in ? ~vpos[2:0] : vpos[2:0];
            r_widx       <= '0;
            r_addr_b     <= {w_row_new, f_word_addr('0, w_flip_in)};
            r_ce_b       <= 4'h0;
            r_cnt        <= CNT_W'(RAM_LAT - 1);
            r_fetch      <= 1'b0;
            r_px         <= '0;
            r_tile_px    <= '0;
            r_tile_valid <= 1'b0;
        end else begin
            unique case (r_state)
                S_F0: begin
                    if (w_lat_done) begin
                        r_active <= dout_b;
                        r_widx   <= w_widx_inc;
                        r_addr_b <= {r_row, f_word_addr(w_widx_inc, r_flip)};
                        r_cnt    <= CNT_W'(RAM_LAT - 1);
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_F1: begin
                    if (w_lat_done) begin
                        r_next       <= dout_b;
                        r_ce_b       <= 4'hF;
                        r_px         <= '0;
                        r_tile_px    <= '0;
                        r_tile_code  <= f_byte(r_active, 2'd0, r_flip);
                        r_tile_valid <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_RUN: begin
                    if (r_fetch) begin
                        if (w_lat_done) begin
                            r_next  <= dout_b;
                            r_ce_b  <= 4'hF;
                            r_fetch <= 1'b0;
                        end else begin
                            r_cnt <= r_cnt - 1'b1;
                        end
                    end
                    if (pix_ce) begin
                        if (w_px_last) begin
                            r_tile_valid <= 1'b0;
                        end else begin
                            r_px        <= w_px_inc;
                            r_tile_px   <= w_px_inc[2:0];
                            r_tile_code <= f_byte(w_src, w_px_inc[4:3], r_flip);
                            if (w_boundary) begin
                                r_active <= r_next;
                                // r_widx tracks the word held in r_next.
                                if (w_more) begin
                                    r_widx   <= w_widx_inc;
                                    r_addr_b <= {r_row, f_word_addr(w_widx_inc, r_flip)};
                                    r_ce_b   <= 4'h0;
                                    r_cnt    <= CNT_W'(RAM_LAT - 1);
                                    r_fetch  <= 1'b1;
                                end
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign addr_b     = r_addr_b;
    assign ce_b       = r_ce_b;
    assign tile_code  = r_tile_code;
    assign tile_line  = r_tile_line;
    assign tile_px    = r_tile_px;
    assign tile_valid = r_tile_valid;

endmodule
